// File: rtl/range_coalesce.sv
// Merges a sorted stream of inclusive ranges into disjoint intervals and sums their sizes.
// Latency: a merged interval appears one cycle after the beat that closed it; the final flush follows in_last.
// Backpressure: in_ready drops while the output slot is full and out_ready is low, and during FLUSH and DONE.
// Optional feature: RANGE_COALESCE_ADJACENT_EN also merges ranges that touch (in_lo == cur_hi + 1).
module range_coalesce #(
    parameter int VAL_W = 64,
    parameter int CNT_W = 72
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_lo,
    input  logic [VAL_W-1:0] in_hi,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_lo,
    output logic [VAL_W-1:0] out_hi,
    output logic [CNT_W-1:0] total_count,
    output logic             done,
    output logic             order_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [VAL_W-1:0] cur_lo;
    logic [VAL_W-1:0] cur_hi;
    logic             cur_valid;

    logic             out_free;
    logic             accept;
    logic             bad_beat;
    logic             overlap;
    logic [CNT_W-1:0] cur_size;
    logic             do_load;
    logic             do_merge;
    logic             do_emit;
    logic             do_flush;

    assign out_free = !out_valid || out_ready;
    assign in_ready = ((state == IDLE) || (state == RUN)) && out_free;
    assign accept   = in_valid && in_ready && !start;
    assign bad_beat = in_lo > in_hi;
    assign done     = (state == DONE);

`ifdef RANGE_COALESCE_ADJACENT_EN
    // One extra bit so cur_hi at the maximum value cannot wrap to zero and falsely match.
    assign overlap = ({1'b0, in_lo} <= ({1'b0, cur_hi} + (VAL_W+1)'(1)));
`else
    assign overlap = (in_lo <= cur_hi);
`endif

    // cur_hi >= cur_lo always holds, so the difference never underflows.
    assign cur_size = CNT_W'(cur_hi) - CNT_W'(cur_lo) + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_merge  = 1'b0;
        do_emit   = 1'b0;
        do_flush  = 1'b0;
        if (start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (accept && !bad_beat) begin
                        if (!cur_valid) begin
                            do_load = 1'b1;
                        end else if (overlap) begin
                            do_merge = 1'b1;
                        end else begin
                            do_emit = 1'b1;
                            do_load = 1'b1;
                        end
                        state_nxt = in_last ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        do_flush  = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_lo      <= '0;
            cur_hi      <= '0;
            cur_valid   <= 1'b0;
            out_valid   <= 1'b0;
            out_lo      <= '0;
            out_hi      <= '0;
            total_count <= '0;
            order_err   <= 1'b0;
        end else if (start) begin
            cur_valid   <= 1'b0;
            out_valid   <= 1'b0;
            total_count <= '0;
            order_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (do_emit || do_flush) begin
                out_lo      <= cur_lo;
                out_hi      <= cur_hi;
                out_valid   <= 1'b1;
                total_count <= total_count + cur_size;
            end
            if (do_load) begin
                cur_lo    <= in_lo;
                cur_hi    <= in_hi;
                cur_valid <= 1'b1;
            end
            if (do_merge && (in_hi > cur_hi)) begin
                cur_hi <= in_hi;
            end
            if (do_flush) begin
                cur_valid <= 1'b0;
            end
            // An out-of-order beat is still merged; only the sticky flag records it.
            if (accept && (bad_beat || (cur_valid && (in_lo < cur_lo)))) begin
                order_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_range_coalesce.sv
// Directed bench for range_coalesce: each task drives one scenario and checks hand-computed results.
module tb_range_coalesce;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_lo = '0;
    logic [63:0] in_hi = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_lo;
    logic [63:0] out_hi;
    logic [71:0] total_count;
    logic        done;
    logic        order_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q_lo[$];
    logic [63:0] q_hi[$];

    range_coalesce #(.VAL_W(64), .CNT_W(72)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_lo(in_lo), .in_hi(in_hi), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
        .total_count(total_count), .done(done), .order_err(order_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && out_valid && out_ready) begin
            q_lo.push_back(out_lo);
            q_hi.push_back(out_hi);
        end
    end

    task automatic send(input logic [63:0] lo, input logic [63:0] hi, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_lo    = lo;
        in_hi    = hi;
        in_last  = last;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for beat %0d-%0d", in_ready, lo, hi);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        q_lo.delete();
        q_hi.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b required 1", done);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_lo !== 64'd0 || out_hi !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%0b lo=%0d hi=%0d required 0 0 0", out_valid, out_lo, out_hi);
        end
        n_checks++;
        if (total_count !== 72'd0 || done !== 1'b0 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: total=%0d done=%0b err=%0b required 0 0 0", total_count, done, order_err);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_basic_merge();
        pulse_start();
        send(64'd3, 64'd5, 1'b0);
        send(64'd10, 64'd14, 1'b0);
        send(64'd12, 64'd18, 1'b0);
        send(64'd16, 64'd20, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flush_in_ready: got %0b required 0", in_ready);
        end
        wait_done();
        n_checks++;
        if (q_lo.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_count: got %0d outputs required 2", q_lo.size());
        end else begin
            n_checks++;
            if (q_lo[0] !== 64'd3 || q_hi[0] !== 64'd5) begin
                n_fail++;
                $display("FAIL basic_out0: got %0d-%0d required 3-5", q_lo[0], q_hi[0]);
            end
            n_checks++;
            if (q_lo[1] !== 64'd10 || q_hi[1] !== 64'd20) begin
                n_fail++;
                $display("FAIL basic_out1: got %0d-%0d required 10-20", q_lo[1], q_hi[1]);
            end
        end
        n_checks++;
        if (total_count !== 72'd14 || done !== 1'b1 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_total: total=%0d done=%0b err=%0b required 14 1 0", total_count, done, order_err);
        end
    endtask

    task automatic test_adjacent();
        pulse_start();
        send(64'd1, 64'd2, 1'b0);
        send(64'd3, 64'd4, 1'b1);
        wait_done();
`ifdef RANGE_COALESCE_ADJACENT_EN
        n_checks++;
        if (q_lo.size() !== 1) begin
            n_fail++;
            $display("FAIL adj_count: got %0d outputs required 1", q_lo.size());
        end else begin
            n_checks++;
            if (q_lo[0] !== 64'd1 || q_hi[0] !== 64'd4) begin
                n_fail++;
                $display("FAIL adj_out0: got %0d-%0d required 1-4", q_lo[0], q_hi[0]);
            end
        end
`else
        n_checks++;
        if (q_lo.size() !== 2) begin
            n_fail++;
            $display("FAIL adj_count: got %0d outputs required 2", q_lo.size());
        end else begin
            n_checks++;
            if (q_lo[0] !== 64'd1 || q_hi[0] !== 64'd2 || q_lo[1] !== 64'd3 || q_hi[1] !== 64'd4) begin
                n_fail++;
                $display("FAIL adj_outs: got %0d-%0d %0d-%0d required 1-2 3-4", q_lo[0], q_hi[0], q_lo[1], q_hi[1]);
            end
        end
`endif
        n_checks++;
        if (total_count !== 72'd4) begin
            n_fail++;
            $display("FAIL adj_total: got %0d required 4", total_count);
        end
    endtask

    task automatic test_backpressure();
        pulse_start();
        out_ready = 1'b0;
        fork
            begin
                send(64'd1, 64'd1, 1'b0);
                send(64'd5, 64'd5, 1'b0);
                send(64'd9, 64'd9, 1'b1);
            end
            begin
                repeat (2) @(negedge clock);
                for (int i = 0; i < 3; i++) begin
                    #2;
                    n_checks++;
                    if (out_valid !== 1'b1 || out_lo !== 64'd1 || out_hi !== 64'd1 || in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: valid=%0b out=%0d-%0d in_ready=%0b required 1 1-1 0",
                                 i, out_valid, out_lo, out_hi, in_ready);
                    end
                    @(negedge clock);
                end
                out_ready = 1'b1;
            end
        join
        wait_done();
        n_checks++;
        if (q_lo.size() !== 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs required 3", q_lo.size());
        end else begin
            n_checks++;
            if (q_lo[0] !== 64'd1 || q_lo[1] !== 64'd5 || q_lo[2] !== 64'd9 || q_hi[2] !== 64'd9) begin
                n_fail++;
                $display("FAIL bp_outs: got %0d %0d %0d-%0d required 1 5 9-9", q_lo[0], q_lo[1], q_lo[2], q_hi[2]);
            end
        end
        n_checks++;
        if (total_count !== 72'd3) begin
            n_fail++;
            $display("FAIL bp_total: got %0d required 3", total_count);
        end
    endtask

    task automatic test_order_err();
        pulse_start();
        send(64'd10, 64'd12, 1'b0);
        send(64'd5, 64'd6, 1'b1);
        wait_done();
        repeat (3) @(negedge clock);
        n_checks++;
        if (order_err !== 1'b1 || total_count !== 72'd3) begin
            n_fail++;
            $display("FAIL order_sticky: err=%0b total=%0d required 1 3", order_err, total_count);
        end
        pulse_start();
        #1;
        n_checks++;
        if (order_err !== 1'b0 || done !== 1'b0 || total_count !== 72'd0) begin
            n_fail++;
            $display("FAIL order_start_clear: err=%0b done=%0b total=%0d required 0 0 0", order_err, done, total_count);
        end
        send(64'd7, 64'd3, 1'b0);
        #1;
        n_checks++;
        if (order_err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || total_count !== 72'd0) begin
            n_fail++;
            $display("FAIL order_drop: err=%0b in_ready=%0b out_valid=%0b total=%0d required 1 1 0 0",
                     order_err, in_ready, out_valid, total_count);
        end
        send(64'd20, 64'd21, 1'b1);
        wait_done();
        n_checks++;
        if (q_lo.size() !== 1 || total_count !== 72'd2) begin
            n_fail++;
            $display("FAIL order_after_drop: outputs=%0d total=%0d required 1 2", q_lo.size(), total_count);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send(64'd1, 64'd2, 1'b0);
        send(64'd4, 64'd5, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_lo !== 64'd0 || out_hi !== 64'd0 || total_count !== 72'd0
            || done !== 1'b0 || order_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%0b out=%0d-%0d total=%0d done=%0b err=%0b required all 0",
                     out_valid, out_lo, out_hi, total_count, done, order_err);
        end
        @(negedge clock);
        reset = 1'b0;
        q_lo.delete();
        q_hi.delete();
        send(64'd0, 64'd0, 1'b1);
        wait_done();
        n_checks++;
        if (total_count !== 72'd1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_new_stream: total=%0d done=%0b required 1 1", total_count, done);
        end
        n_checks++;
        if (q_lo.size() !== 1 || q_lo[0] !== 64'd0 || q_hi[0] !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_new_out: outputs=%0d required one 0-0", q_lo.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_merge();
        test_adjacent();
        test_backpressure();
        test_order_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
